// File: rtl/axi_wr_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_slave_if
// Purpose  : AXI3 write-side bundle (AW, W and B channels) shared between
//            a write master and the axi_wr_slave responder.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_wr_slave_if;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_slave
// Purpose  : AXI3 write slave. Accepts one burst at a time, turns each W beat
//            into a one-cycle SRAM-style write, then answers on the B channel
//            after an optional fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_slave #(
  parameter int unsigned B_LATENCY = 0
) (
  input  wire          clk,
  input  wire          resetn,
  axi_wr_slave_if.slave bus,
  output logic [3:0]   ram_wen,
  output logic [31:0]  ram_addr,
  output logic [31:0]  ram_wdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam bit         HAS_WAIT    = (B_LATENCY != 0);
  // WAIT holds for B_LATENCY cycles, so the counter starts one below it.
  localparam logic [3:0] WAIT_INIT   = HAS_WAIT ? 4'(B_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  burst_id;
  logic [31:0] cur_addr;
  logic [7:0]  burst_len;
  logic [2:0]  burst_size;
  logic [1:0]  burst_type;
  logic [7:0]  beat_cnt;
  logic        err;
  logic [3:0]  wait_cnt;

  logic        awready;
  logic        wready;
  logic        bvalid;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        last_beat;
  logic        aw_err;
  logic        beat_err;

  assign aw_hs     = bus.awvalid && awready;
  assign w_hs      = bus.wvalid && wready;
  assign b_hs      = bus.bready && bvalid;
  // The counter alone decides where a burst ends; wlast is only checked.
  assign last_beat = w_hs && (beat_cnt == burst_len);
  assign aw_err    = bus.awburst[1] || (bus.awsize > 3'd2) || (bus.awlen > 8'd15);
  assign beat_err  = (bus.wid != burst_id) || (bus.wlast != (beat_cnt == burst_len));

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = burst_id;
  assign bus.bresp   = err ? RESP_SLVERR : RESP_OKAY;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; ready/valid come straight from the registered state.
  always_comb begin
    state_next = state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    unique case (state)
      IDLE: begin
        awready = 1'b1;
        if (aw_hs) state_next = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (last_beat) state_next = HAS_WAIT ? WAIT : RESP;
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (b_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst context, beat tracking, response latency and the RAM write port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      burst_id   <= 4'd0;
      cur_addr   <= 32'd0;
      burst_len  <= 8'd0;
      burst_size <= 3'd0;
      burst_type <= 2'd0;
      beat_cnt   <= 8'd0;
      err        <= 1'b0;
      wait_cnt   <= 4'd0;
      ram_wen    <= 4'd0;
      ram_addr   <= 32'd0;
      ram_wdata  <= 32'd0;
    end else begin
      ram_wen <= 4'd0;

      if (aw_hs) begin
        burst_id   <= bus.awid;
        cur_addr   <= bus.awaddr;
        burst_len  <= bus.awlen;
        burst_size <= bus.awsize;
        burst_type <= bus.awburst;
        beat_cnt   <= 8'd0;
        err        <= aw_err;
      end

      if (w_hs) begin
        // The write uses the error state as it stood before this beat.
        ram_wen   <= err ? 4'd0 : bus.wstrb;
        ram_addr  <= {cur_addr[31:2], 2'b00};
        ram_wdata <= bus.wdata;
        if (burst_type == BURST_INCR) begin
          cur_addr <= cur_addr + (32'd1 << burst_size);
        end else if (burst_type == BURST_FIXED) begin
          cur_addr <= cur_addr;
        end
        beat_cnt <= beat_cnt + 8'd1;
        if (beat_err) err <= 1'b1;
      end

      if (last_beat) begin
        wait_cnt <= WAIT_INIT;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_slave
// Purpose  : Self-checking bench for axi_wr_slave. Two instances (response
//            latency 0 and 3) share one stimulus bus; only the selected one
//            is out of reset and observed at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn0;
  logic rstn3;
  bit   sel;

  // Shared master-side drive
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        bready;

  axi_wr_slave_if bus0 ();
  axi_wr_slave_if bus3 ();

  logic [3:0]  ram_wen0, ram_wen3;
  logic [31:0] ram_addr0, ram_addr3, ram_wdata0, ram_wdata3;

  axi_wr_slave #(.B_LATENCY(0)) dut0 (
    .clk(clk), .resetn(rstn0), .bus(bus0),
    .ram_wen(ram_wen0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0)
  );

  axi_wr_slave #(.B_LATENCY(3)) dut3 (
    .clk(clk), .resetn(rstn3), .bus(bus3),
    .ram_wen(ram_wen3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3)
  );

  assign bus0.awid = awid;       assign bus3.awid = awid;
  assign bus0.awaddr = awaddr;   assign bus3.awaddr = awaddr;
  assign bus0.awlen = awlen;     assign bus3.awlen = awlen;
  assign bus0.awsize = awsize;   assign bus3.awsize = awsize;
  assign bus0.awburst = awburst; assign bus3.awburst = awburst;
  assign bus0.awvalid = awvalid; assign bus3.awvalid = awvalid;
  assign bus0.wid = wid;         assign bus3.wid = wid;
  assign bus0.wdata = wdata;     assign bus3.wdata = wdata;
  assign bus0.wstrb = wstrb;     assign bus3.wstrb = wstrb;
  assign bus0.wlast = wlast;     assign bus3.wlast = wlast;
  assign bus0.wvalid = wvalid;   assign bus3.wvalid = wvalid;
  assign bus0.bready = bready;   assign bus3.bready = bready;

  // Observed outputs of whichever instance is under test
  logic        awready, wready, bvalid;
  logic [3:0]  bid, ram_wen;
  logic [1:0]  bresp;
  logic [31:0] ram_addr, ram_wdata;
  assign awready   = sel ? bus3.awready : bus0.awready;
  assign wready    = sel ? bus3.wready  : bus0.wready;
  assign bvalid    = sel ? bus3.bvalid  : bus0.bvalid;
  assign bid       = sel ? bus3.bid     : bus0.bid;
  assign bresp     = sel ? bus3.bresp   : bus0.bresp;
  assign ram_wen   = sel ? ram_wen3     : ram_wen0;
  assign ram_addr  = sel ? ram_addr3    : ram_addr0;
  assign ram_wdata = sel ? ram_wdata3   : ram_wdata0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model of one burst: expected write address of beat i is the
  // start address plus i steps for INCR, the start address for FIXED; the
  // response is SLVERR when any AW rule or any beat rule was broken.
  task automatic do_burst(
    input  logic [3:0]  id,    input logic [31:0] addr, input logic [7:0] len,
    input  logic [2:0]  size,  input logic [1:0]  bt,   input logic [31:0] dbase,
    input  bit          walk,  input int early,         input bit wid_bad,
    input  int          lat,   input int gap_max,       input int bdelay,
    output logic [1:0]  got_resp, output logic [31:0] got_last
  );
    bit          aw_err, any_fault, fault;
    logic [31:0] exp_addr;
    logic [3:0]  strb;
    logic [3:0]  hold_bid;
    logic [1:0]  exp_resp;
    int          n;
    int          gap;
    aw_err    = bt[1] || (size > 3'd2) || (len > 8'd15);
    any_fault = 1'b0;
    got_last  = 32'd0;

    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1'b1);

    for (int i = 0; i <= int'(len); i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      wvalid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        chk("ram_wen_idle_gap", ram_wen, 4'd0);
      end
      wid    = (wid_bad && i == 0) ? (id ^ 4'h1) : id;
      wdata  = dbase + 32'(i);
      strb   = walk ? 4'(1 << (i % 4)) : 4'hF;
      wstrb  = strb;
      wlast  = (early >= 0) ? (i == early) : (i == int'(len));
      wvalid = 1'b1;
      fault  = (wid != id) || (wlast != (i == int'(len)));
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk("w_accept_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); @(negedge clk);
      exp_addr = (bt == 2'b01) ? addr + 32'(i) * (32'd1 << size) : addr;
      if (!bt[1]) chk("ram_addr", ram_addr, {exp_addr[31:2], 2'b00});
      chk("ram_wdata", ram_wdata, dbase + 32'(i));
      if (!any_fault && !fault) chk("ram_wen", ram_wen, aw_err ? 4'd0 : strb);
      chk("awready_busy", awready, 1'b0);
      got_last  = ram_addr;
      any_fault = any_fault || fault;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;

    n = 0;
    while (!bvalid && n < 40) begin
      chk("awready_wait", awready, 1'b0);
      @(negedge clk);
      n++;
    end
    chk("b_latency", 32'(n), 32'(lat));
    exp_resp = (aw_err || any_fault) ? 2'b10 : 2'b00;
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    got_resp = bresp;
    hold_bid = bid;
    repeat (bdelay) begin
      @(negedge clk);
      chk("bvalid_held", bvalid, 1'b1);
      chk("bid_stable", bid, hold_bid);
      chk("bresp_stable", bresp, exp_resp);
      chk("awready_before_b", awready, 1'b0);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    chk("bvalid_after_b", bvalid, 1'b0);
    chk("awready_after_b", awready, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_bid"}, bid, 4'd0);
    chk({tag, "_bresp"}, bresp, 2'd0);
    chk({tag, "_ram_wen"}, ram_wen, 4'd0);
    chk({tag, "_ram_addr"}, ram_addr, 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  bt;
    logic [31:0] data;
    bit          walk;
    int          early;
    bit          wid_bad;
    logic [1:0]  exp_resp;
    bit          chk_last;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] last;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_bt;
    int          r_early;

    tbl[0]  = '{4'd5,  32'h0000_0100, 8'd0,  3'd2, 2'b01, 32'hDEAD_BEEF, 1'b0, -1, 1'b0, 2'b00, 1'b1, 32'h0000_0100};
    tbl[1]  = '{4'd3,  32'h0000_1FFC, 8'd3,  3'd2, 2'b01, 32'h1111_0000, 1'b0, -1, 1'b0, 2'b00, 1'b1, 32'h0000_2008};
    tbl[2]  = '{4'd9,  32'h0000_0202, 8'd3,  3'd0, 2'b00, 32'h2222_0000, 1'b1, -1, 1'b0, 2'b00, 1'b1, 32'h0000_0200};
    tbl[3]  = '{4'd7,  32'h0000_0400, 8'd2,  3'd2, 2'b10, 32'h3333_0000, 1'b0, -1, 1'b0, 2'b10, 1'b0, 32'h0};
    tbl[4]  = '{4'd2,  32'h0000_0500, 8'd2,  3'd2, 2'b01, 32'h4444_0000, 1'b0,  1, 1'b0, 2'b10, 1'b1, 32'h0000_0508};
    tbl[5]  = '{4'd1,  32'h0000_0600, 8'd1,  3'd3, 2'b01, 32'h5555_0000, 1'b0, -1, 1'b0, 2'b10, 1'b1, 32'h0000_0608};
    tbl[6]  = '{4'd4,  32'h0000_0700, 8'd16, 3'd2, 2'b01, 32'h6666_0000, 1'b0, -1, 1'b0, 2'b10, 1'b1, 32'h0000_0740};
    tbl[7]  = '{4'd6,  32'hFFFF_FFFC, 8'd1,  3'd2, 2'b01, 32'h7777_0000, 1'b0, -1, 1'b0, 2'b00, 1'b1, 32'h0000_0000};
    tbl[8]  = '{4'd8,  32'h0000_0010, 8'd2,  3'd1, 2'b01, 32'h8888_0000, 1'b0, -1, 1'b0, 2'b00, 1'b1, 32'h0000_0014};
    tbl[9]  = '{4'd10, 32'h0000_0800, 8'd1,  3'd2, 2'b01, 32'h9999_0000, 1'b0, -1, 1'b1, 2'b10, 1'b1, 32'h0000_0804};
    tbl[10] = '{4'd15, 32'h0000_0900, 8'd15, 3'd2, 2'b01, 32'hAAAA_0000, 1'b0, -1, 1'b0, 2'b00, 1'b1, 32'h0000_093C};
    tbl[11] = '{4'd0,  32'h0000_0A00, 8'd1,  3'd2, 2'b11, 32'hBBBB_0000, 1'b0, -1, 1'b0, 2'b10, 1'b0, 32'h0};

    sel = 1'b0; rstn0 = 1'b0; rstn3 = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rstn0 = 1'b1;
    @(negedge clk);
    chk("awready_post_reset", awready, 1'b1);

    // W beats offered while idle are not taken
    wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_wready", wready, 1'b0);
      chk("idle_ram_wen", ram_wen, 4'd0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    // Directed vector table on the zero-latency instance
    for (int v = 0; v < 12; v++) begin
      do_burst(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].bt, tbl[v].data,
               tbl[v].walk, tbl[v].early, tbl[v].wid_bad, 0, 0, 0, resp, last);
      chk($sformatf("tbl%0d_bresp", v), resp, tbl[v].exp_resp);
      if (tbl[v].chk_last) chk($sformatf("tbl%0d_last_addr", v), last, tbl[v].exp_last);
    end

    // Reset in the middle of a 4-beat burst, after 2 beats
    awid = 4'd11; awaddr = 32'h0000_3000; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wid = 4'd11; wdata = 32'h5A5A_0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("pre_reset_ram_wen", ram_wen, 4'hF);
    end
    rstn0 = 1'b0; wvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_reset_state("midburst_reset");
    rstn0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_b_after_reset", bvalid, 1'b0);
      chk("no_wen_after_reset", ram_wen, 4'd0);
    end
    do_burst(4'd12, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 32'h1234_5678, 1'b0, -1, 1'b0, 0, 0, 0, resp, last);
    chk("post_reset_bresp", resp, 2'b00);

    // Randomized bursts against the reference model, zero latency
    for (int k = 0; k < 40; k++) begin
      r_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 18)) : 8'($urandom_range(0, 15));
      r_size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r_bt    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      r_early = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
      do_burst(4'($urandom), 32'($urandom), r_len, r_size, r_bt, 32'($urandom), 1'($urandom),
               r_early, ($urandom_range(0, 9) == 0), 0, 2, int'($urandom_range(0, 3)), resp, last);
    end

    // Switch to the B_LATENCY=3 instance
    @(negedge clk);
    rstn0 = 1'b0; sel = 1'b1; rstn3 = 1'b1;
    @(negedge clk);
    chk("lat3_awready", awready, 1'b1);

    // Backpressure: bready low for 5 cycles after bvalid
    do_burst(4'd13, 32'h0000_4000, 8'd1, 3'd2, 2'b01, 32'h0BAD_CAFE, 1'b0, -1, 1'b0, 3, 0, 5, resp, last);
    chk("bp_bresp", resp, 2'b00);
    chk("bp_last_addr", last, 32'h0000_4004);

    for (int k = 0; k < 10; k++) begin
      r_len  = 8'($urandom_range(0, 7));
      r_bt   = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      do_burst(4'($urandom), 32'($urandom), r_len, 3'($urandom_range(0, 2)), r_bt, 32'($urandom),
               1'b0, -1, ($urandom_range(0, 4) == 0), 3, 1, int'($urandom_range(0, 4)), resp, last);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
